// File: rtl/key_slot_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_slot_arbiter_if : requester-side bus of the shared key slot arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface key_slot_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int KEY_W   = 128
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ-1:0]       rel;
   logic [NUM_REQ*KEY_W-1:0] key_in;
   logic [NUM_REQ-1:0]       key_valid;
   logic [NUM_REQ-1:0]       use_pulse;
   logic [NUM_REQ-1:0]       grant;
   logic [2:0]               owner_id;
   logic [KEY_W-1:0]         key_out;
   logic                     key_ready;
   logic                     scrubbing;
   logic                     timeout_err;

   modport master (
      output req, rel, key_in, key_valid, use_pulse,
      input  grant, owner_id, key_out, key_ready, scrubbing, timeout_err
   );

   modport slave (
      input  req, rel, key_in, key_valid, use_pulse,
      output grant, owner_id, key_out, key_ready, scrubbing, timeout_err
   );
endinterface
`default_nettype wire

// File: rtl/key_slot_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_slot_arbiter : round-robin owner of one key register, zeroized per owner
// Revision: 1.0
// ---------------------------------------------------------------------------
module key_slot_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int KEY_W        = 128,
   parameter int TIMEOUT      = 255,
   parameter int SCRUB_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   key_slot_arbiter_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ACTIVE, ST_SCRUB} state_t;

   localparam int              SC_W         = $clog2(SCRUB_CYCLES) + 1;
   localparam logic [15:0]     C_TMO_LAST   = 16'(TIMEOUT - 1);
   localparam logic [SC_W-1:0] C_SCRUB_LAST = SC_W'(SCRUB_CYCLES - 1);

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [2:0]         owner_q, owner_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic               ready_q, ready_d;
   logic               scrub_q, scrub_d;
   logic               tmo_err_q, tmo_err_d;
   logic [15:0]        timer_q, timer_d;
   logic [SC_W-1:0]    scnt_q, scnt_d;
   logic [2:0]         rr_q, rr_d;

   logic               hi_found, lo_found, go_scrub;
   logic [2:0]         hi_idx, lo_idx, win_idx;
   logic [KEY_W-1:0]   sel_key;
   logic               own_kv, own_rel, own_use;

   // Descending scan leaves the lowest set index at or above rr_q in hi_idx,
   // and the lowest set index overall in lo_idx for the wrap-around case.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = 3'd0;
      lo_idx   = 3'd0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            lo_found = 1'b1;
            lo_idx   = 3'(i);
            if (3'(i) >= rr_q) begin
               hi_found = 1'b1;
               hi_idx   = 3'(i);
            end
         end
      end
      win_idx = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      sel_key = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) sel_key = bus.key_in[i*KEY_W +: KEY_W];
      end
   end

   // grant_q is one-hot, so masking with it keeps only the owner's strobes
   assign own_kv  = |(bus.key_valid & grant_q);
   assign own_rel = |(bus.rel & grant_q);
   assign own_use = |(bus.use_pulse & grant_q);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      key_d     = key_q;
      ready_d   = ready_q;
      scrub_d   = scrub_q;
      tmo_err_d = 1'b0;
      timer_d   = timer_q;
      scnt_d    = scnt_q;
      rr_d      = rr_q;
      go_scrub  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (lo_found) begin
               state_d = ST_LOAD;
               grant_d = NUM_REQ'(1) << win_idx;
               owner_d = win_idx;
               rr_d    = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
               timer_d = 16'd0;
            end
         end
         ST_LOAD, ST_ACTIVE: begin
            if (own_rel) begin
               go_scrub = 1'b1;
            end else if (own_kv && state_q == ST_LOAD) begin
               key_d   = sel_key;
               ready_d = 1'b1;
               state_d = ST_ACTIVE;
               timer_d = 16'd0;
            end else if (own_use) begin
               timer_d = 16'd0;
            end else if (timer_q == C_TMO_LAST) begin
               tmo_err_d = 1'b1;
               go_scrub  = 1'b1;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         ST_SCRUB: begin
            if (scnt_q == C_SCRUB_LAST) begin
               state_d = ST_IDLE;
               scrub_d = 1'b0;
               scnt_d  = '0;
            end else begin
               scnt_d = scnt_q + SC_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (go_scrub) begin
         state_d = ST_SCRUB;
         key_d   = '0;
         ready_d = 1'b0;
         grant_d = '0;
         owner_d = 3'd0;
         scrub_d = 1'b1;
         scnt_d  = '0;
         timer_d = 16'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         owner_q   <= 3'd0;
         key_q     <= '0;
         ready_q   <= 1'b0;
         scrub_q   <= 1'b0;
         tmo_err_q <= 1'b0;
         timer_q   <= 16'd0;
         scnt_q    <= '0;
         rr_q      <= 3'd0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         key_q     <= key_d;
         ready_q   <= ready_d;
         scrub_q   <= scrub_d;
         tmo_err_q <= tmo_err_d;
         timer_q   <= timer_d;
         scnt_q    <= scnt_d;
         rr_q      <= rr_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.owner_id    = owner_q;
   assign bus.key_out     = key_q;
   assign bus.key_ready   = ready_q;
   assign bus.scrubbing   = scrub_q;
   assign bus.timeout_err = tmo_err_q;
endmodule
`default_nettype wire

// File: tb/tb_key_slot_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_key_slot_arbiter : directed self-checking bench for key_slot_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_key_slot_arbiter;
   localparam logic [127:0] K0    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] K1    = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
   localparam logic [127:0] K2    = 128'hCAFEF00D_12345678_9ABCDEF0_13579BDF;
   localparam logic [127:0] KDEAD = {4{32'hDEADBEEF}};

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   key_slot_arbiter_if #(.NUM_REQ(4), .KEY_W(128)) bus ();

   key_slot_arbiter #(
      .NUM_REQ(4), .KEY_W(128), .TIMEOUT(8), .SCRUB_CYCLES(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req       = '0;
      bus.rel       = '0;
      bus.key_valid = '0;
      bus.use_pulse = '0;
      bus.key_in    = '0;
      steps(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({bus.grant, bus.owner_id, bus.key_ready, bus.scrubbing, bus.timeout_err} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl actual=%b required=%b",
                  {bus.grant, bus.owner_id, bus.key_ready, bus.scrubbing, bus.timeout_err}, 10'b0);
      end
      n_checks++;
      if (bus.key_out !== 128'h0) begin
         n_fail++; $display("FAIL reset_key actual=%h required=0", bus.key_out);
      end
   endtask

   task automatic test_single_owner();
      bus.req = 4'b0001;
      step();
      n_checks++;
      if ({bus.grant, bus.owner_id, bus.key_ready} !== {4'b0001, 3'd0, 1'b0}) begin
         n_fail++; $display("FAIL single_grant actual=%b required=%b",
                            {bus.grant, bus.owner_id, bus.key_ready}, {4'b0001, 3'd0, 1'b0});
      end
      bus.req           = 4'b0000;
      bus.key_in[127:0] = K0;
      bus.key_valid     = 4'b0001;
      step();
      bus.key_valid = 4'b0000;
      n_checks++;
      if (bus.key_out !== K0 || bus.key_ready !== 1'b1 || bus.grant !== 4'b0001) begin
         n_fail++; $display("FAIL single_load key=%h ready=%b grant=%b required key=%h ready=1 grant=0001",
                            bus.key_out, bus.key_ready, bus.grant, K0);
      end
      bus.rel = 4'b0001;
      step();
      bus.rel = 4'b0000;
      n_checks++;
      if (bus.key_out !== 128'h0 || bus.scrubbing !== 1'b1 || bus.grant !== 4'b0 || bus.key_ready !== 1'b0) begin
         n_fail++; $display("FAIL single_rel key=%h scrub=%b grant=%b ready=%b required 0/1/0000/0",
                            bus.key_out, bus.scrubbing, bus.grant, bus.key_ready);
      end
      step();
      n_checks++;
      if (bus.key_out !== 128'h0 || bus.scrubbing !== 1'b1) begin
         n_fail++; $display("FAIL single_scrub2 key=%h scrub=%b required 0/1", bus.key_out, bus.scrubbing);
      end
      step();
      n_checks++;
      if (bus.scrubbing !== 1'b0 || bus.grant !== 4'b0) begin
         n_fail++; $display("FAIL single_idle scrub=%b grant=%b required 0/0000", bus.scrubbing, bus.grant);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0]   exp_g;
      logic [127:0] k;
      int           idx;
      int           wait_n;
      int           exp_wait;
      logic         key_zero;
      do_reset();
      bus.req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         idx      = n % 4;
         exp_g    = 4'b0001 << idx;
         exp_wait = (n == 0) ? 1 : 3;
         wait_n   = 0;
         key_zero = 1'b1;
         while (bus.grant === 4'b0 && wait_n < 10) begin
            if (bus.key_out !== 128'h0) key_zero = 1'b0;
            step();
            wait_n++;
         end
         n_checks++;
         if (bus.grant !== exp_g || bus.owner_id !== 3'(idx) || wait_n != exp_wait || !key_zero) begin
            n_fail++; $display("FAIL rr_grant%0d grant=%b owner=%0d wait=%0d keyzero=%b required %b/%0d/%0d/1",
                               n, bus.grant, bus.owner_id, wait_n, key_zero, exp_g, idx, exp_wait);
         end
         k = {4{32'h5A5A0000 + 32'(n)}};
         bus.key_in[idx*128 +: 128] = k;
         bus.key_valid = exp_g;
         step();
         bus.key_valid = 4'b0;
         n_checks++;
         if (bus.key_out !== k || bus.key_ready !== 1'b1) begin
            n_fail++; $display("FAIL rr_load%0d key=%h ready=%b required %h/1", n, bus.key_out, bus.key_ready, k);
         end
         bus.rel = exp_g;
         if (n == 4) bus.req = 4'b0;
         step();
         bus.rel = 4'b0;
         n_checks++;
         if (bus.key_out !== 128'h0 || bus.scrubbing !== 1'b1) begin
            n_fail++; $display("FAIL rr_rel%0d key=%h scrub=%b required 0/1", n, bus.key_out, bus.scrubbing);
         end
      end
      steps(3);
   endtask

   task automatic test_timeout();
      bus.req = 4'b0001;
      step();
      bus.req = 4'b0000;
      n_checks++;
      if (bus.grant !== 4'b0001) begin
         n_fail++; $display("FAIL tmo_grant actual=%b required=0001", bus.grant);
      end
      bus.key_in[127:0] = K1;
      bus.key_valid     = 4'b0001;
      step();
      bus.key_valid = 4'b0;
      n_checks++;
      if (bus.key_ready !== 1'b1 || bus.key_out !== K1) begin
         n_fail++; $display("FAIL tmo_load ready=%b key=%h required 1/%h", bus.key_ready, bus.key_out, K1);
      end
      for (int c = 1; c <= 8; c++) begin
         step();
         n_checks++;
         if (bus.timeout_err !== (c == 8)) begin
            n_fail++; $display("FAIL tmo_pulse_c%0d actual=%b required=%b", c, bus.timeout_err, (c == 8));
         end
      end
      step();
      n_checks++;
      if (bus.timeout_err !== 1'b0 || bus.key_out !== 128'h0 || bus.key_ready !== 1'b0 || bus.grant !== 4'b0) begin
         n_fail++; $display("FAIL tmo_after err=%b key=%h ready=%b grant=%b required 0/0/0/0000",
                            bus.timeout_err, bus.key_out, bus.key_ready, bus.grant);
      end
      steps(3);
   endtask

   task automatic test_timeout_restart();
      int bad;
      bus.req = 4'b0010;
      step();
      bus.req = 4'b0;
      n_checks++;
      if (bus.grant !== 4'b0010 || bus.owner_id !== 3'd1) begin
         n_fail++; $display("FAIL restart_grant grant=%b owner=%0d required 0010/1", bus.grant, bus.owner_id);
      end
      bus.key_in[128 +: 128] = K2;
      bus.key_valid          = 4'b0010;
      step();
      bus.key_valid = 4'b0;
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         bus.use_pulse = (c % 5 == 4) ? 4'b0010 : 4'b0000;
         step();
         n_checks++;
         if (bus.timeout_err !== 1'b0 || bus.key_out !== K2 || bus.key_ready !== 1'b1) begin
            n_fail++; bad++;
            if (bad < 4) $display("FAIL restart_c%0d err=%b key=%h required 0/%h", c, bus.timeout_err, bus.key_out, K2);
         end
      end
      bus.use_pulse = 4'b0;
      bus.rel       = 4'b0010;
      step();
      bus.rel = 4'b0;
      steps(3);
   endtask

   task automatic test_non_owner();
      bus.req = 4'b0100;
      step();
      bus.req = 4'b0;
      n_checks++;
      if (bus.grant !== 4'b0100 || bus.owner_id !== 3'd2) begin
         n_fail++; $display("FAIL iso_grant grant=%b owner=%0d required 0100/2", bus.grant, bus.owner_id);
      end
      bus.key_in[128 +: 128] = KDEAD;
      bus.key_valid          = 4'b0010;
      step();
      n_checks++;
      if (bus.key_ready !== 1'b0 || bus.key_out !== 128'h0) begin
         n_fail++; $display("FAIL iso_load_kv ready=%b key=%h required 0/0", bus.key_ready, bus.key_out);
      end
      bus.key_in[256 +: 128] = K2;
      bus.key_valid          = 4'b0100;
      step();
      bus.key_valid = 4'b0010;
      bus.rel       = 4'b0010;
      step();
      bus.key_valid = 4'b0;
      bus.rel       = 4'b0;
      n_checks++;
      if (bus.key_out !== K2 || bus.key_ready !== 1'b1 || bus.grant !== 4'b0100 || bus.scrubbing !== 1'b0) begin
         n_fail++; $display("FAIL iso_active key=%h ready=%b grant=%b scrub=%b required %h/1/0100/0",
                            bus.key_out, bus.key_ready, bus.grant, bus.scrubbing, K2);
      end
      bus.key_in[256 +: 128] = KDEAD;
      bus.key_valid          = 4'b0100;
      step();
      bus.key_valid = 4'b0;
      n_checks++;
      if (bus.key_out !== K2) begin
         n_fail++; $display("FAIL iso_owner_reload actual=%h required=%h", bus.key_out, K2);
      end
      bus.use_pulse = 4'b0100;
      step();
      bus.use_pulse = 4'b0;
      steps(7);
      n_checks++;
      if (bus.timeout_err !== 1'b0 || bus.key_ready !== 1'b1) begin
         n_fail++; $display("FAIL tie_pre err=%b ready=%b required 0/1", bus.timeout_err, bus.key_ready);
      end
      bus.rel = 4'b0100;
      step();
      bus.rel = 4'b0;
      n_checks++;
      if (bus.timeout_err !== 1'b0 || bus.scrubbing !== 1'b1 || bus.key_out !== 128'h0) begin
         n_fail++; $display("FAIL tie_rel err=%b scrub=%b key=%h required 0/1/0",
                            bus.timeout_err, bus.scrubbing, bus.key_out);
      end
      steps(3);
   endtask

   task automatic test_reset_active();
      bus.req = 4'b0010;
      step();
      bus.req                = 4'b0;
      bus.key_in[128 +: 128] = K1;
      bus.key_valid          = 4'b0010;
      step();
      bus.key_valid = 4'b0;
      n_checks++;
      if (bus.grant !== 4'b0010 || bus.key_ready !== 1'b1 || bus.key_out !== K1) begin
         n_fail++; $display("FAIL rstact_pre grant=%b ready=%b key=%h required 0010/1/%h",
                            bus.grant, bus.key_ready, bus.key_out, K1);
      end
      rst     = 1'b1;
      bus.req = 4'b1111;
      step();
      n_checks++;
      if (bus.key_out !== 128'h0 || bus.grant !== 4'b0 || bus.key_ready !== 1'b0 || bus.timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL rstact_clear key=%h grant=%b ready=%b err=%b required 0/0000/0/0",
                            bus.key_out, bus.grant, bus.key_ready, bus.timeout_err);
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (bus.grant !== 4'b0001 || bus.owner_id !== 3'd0) begin
         n_fail++; $display("FAIL rstact_rr grant=%b owner=%0d required 0001/0", bus.grant, bus.owner_id);
      end
      bus.req = 4'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single_owner();
      test_round_robin();
      test_timeout();
      test_timeout_restart();
      test_non_owner();
      test_reset_active();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end
endmodule
`default_nettype wire
